// File: rtl/ex_pipe_pkg.sv
// Shared types for the ID->EX pipeline register.
//   reg_idx_t : architectural register index (x0..x31)
//   ex_meta_t : predictor sideband carried alongside the instruction
//   REG_X0    : hard-wired zero register, never forwarded into
package ex_pipe_pkg;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    logic       btb_hit;
    logic       prediction;
    logic [3:0] pattern_used;
  } ex_meta_t;

  localparam reg_idx_t REG_X0 = 5'd0;

endpackage

// File: rtl/ex_stage_reg_if.sv
// Bundle between ID/WB (master side) and the ID->EX register (slave side).
//   master : drives load/flush/hold_patch, ID fields and WB ports; reads EX fields
//   slave  : the pipeline register itself
interface ex_stage_reg_if
  import ex_pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int NUM_WB  = 1,
  parameter int META_W  = 6,
  parameter int CNT_W   = 4
);

  logic                               load;
  logic                               flush;
  logic                               hold_patch;
  logic                               id_valid;
  logic [XLEN-1:0]                    id_pc;
  reg_idx_t [NUM_SRC-1:0]             id_src_idx;
  logic     [NUM_SRC-1:0][XLEN-1:0]   id_src_val;
  logic [META_W-1:0]                  id_meta;
  logic     [NUM_WB-1:0]              wb_we;
  reg_idx_t [NUM_WB-1:0]              wb_rd;
  logic     [NUM_WB-1:0][XLEN-1:0]    wb_data;

  logic                               ex_valid;
  logic [XLEN-1:0]                    ex_pc;
  reg_idx_t [NUM_SRC-1:0]             ex_src_idx;
  logic     [NUM_SRC-1:0][XLEN-1:0]   ex_src_val;
  logic [META_W-1:0]                  ex_meta;
  logic [CNT_W-1:0]                   ex_stall_cnt;

  modport master (
    output load, flush, hold_patch, id_valid, id_pc, id_src_idx, id_src_val, id_meta,
           wb_we, wb_rd, wb_data,
    input  ex_valid, ex_pc, ex_src_idx, ex_src_val, ex_meta, ex_stall_cnt
  );

  modport slave (
    input  load, flush, hold_patch, id_valid, id_pc, id_src_idx, id_src_val, id_meta,
           wb_we, wb_rd, wb_data,
    output ex_valid, ex_pc, ex_src_idx, ex_src_val, ex_meta, ex_stall_cnt
  );

endinterface

// File: rtl/ex_fwd_patch.sv
// Combinational operand patch: replaces v with the data of the first
// writeback port (port 0 highest priority) that writes register idx.
// x0 is never replaced.
//   idx, v   : operand register index and current value
//   wb_*     : writeback ports
//   res      : patched operand
module ex_fwd_patch
  import ex_pipe_pkg::*;
#(
  parameter int NUM_WB = 1,
  parameter int XLEN   = 32
) (
  input  reg_idx_t                         idx,
  input  logic     [XLEN-1:0]              v,
  input  logic     [NUM_WB-1:0]            wb_we,
  input  reg_idx_t [NUM_WB-1:0]            wb_rd,
  input  logic     [NUM_WB-1:0][XLEN-1:0]  wb_data,
  output logic     [XLEN-1:0]              res
);

  // Scan from the oldest port down so the youngest (port 0) overwrites last.
  always_comb begin
    res = v;
    for (int j = NUM_WB - 1; j >= 0; j--) begin
      if (wb_we[j] && (wb_rd[j] == idx) && (idx != REG_X0)) begin
        res = wb_data[j];
      end
    end
  end

endmodule

// File: rtl/ex_stage_reg.sv
// ID->EX pipeline register with writeback patching while held, flush to
// bubble, optional patch on load, and a saturating stalled-cycle counter.
//   clk, reset : clock, synchronous active-high reset (clears all outputs)
//   bus        : ex_stage_reg_if slave (control, ID fields, WB ports, EX fields)
// Priority per edge: reset > flush > load > hold_patch > idle hold.
module ex_stage_reg
  import ex_pipe_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int NUM_SRC       = 2,
  parameter int NUM_WB        = 1,
  parameter int META_W        = 6,
  parameter bit PATCH_ON_LOAD = 1'b1,
  parameter int CNT_W         = 4
) (
  input logic          clk,
  input logic          reset,
  ex_stage_reg_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                             valid_q,     valid_d;
  logic     [XLEN-1:0]              pc_q,        pc_d;
  reg_idx_t [NUM_SRC-1:0]           src_idx_q,   src_idx_d;
  logic     [NUM_SRC-1:0][XLEN-1:0] src_val_q,   src_val_d;
  logic     [META_W-1:0]            meta_q,      meta_d;
  logic     [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;

  logic [NUM_SRC-1:0][XLEN-1:0] hold_val;
  logic [NUM_SRC-1:0][XLEN-1:0] load_val;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    ex_fwd_patch #(.NUM_WB(NUM_WB), .XLEN(XLEN)) u_hold_patch (
      .idx     (src_idx_q[i]),
      .v       (src_val_q[i]),
      .wb_we   (bus.wb_we),
      .wb_rd   (bus.wb_rd),
      .wb_data (bus.wb_data),
      .res     (hold_val[i])
    );

    if (PATCH_ON_LOAD) begin : g_load_patch
      // Catches a writeback landing in the same cycle the operand leaves ID.
      ex_fwd_patch #(.NUM_WB(NUM_WB), .XLEN(XLEN)) u_load_patch (
        .idx     (bus.id_src_idx[i]),
        .v       (bus.id_src_val[i]),
        .wb_we   (bus.wb_we),
        .wb_rd   (bus.wb_rd),
        .wb_data (bus.wb_data),
        .res     (load_val[i])
      );
    end else begin : g_load_pass
      assign load_val[i] = bus.id_src_val[i];
    end
  end

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    src_idx_d   = src_idx_q;
    src_val_d   = src_val_q;
    meta_d      = meta_q;
    stall_cnt_d = stall_cnt_q;
    if (bus.flush) begin
      // pc/idx/val are left as-is; ex_valid=0 makes them don't-care.
      valid_d     = 1'b0;
      meta_d      = '0;
      stall_cnt_d = '0;
    end else if (bus.load) begin
      valid_d     = bus.id_valid;
      pc_d        = bus.id_pc;
      src_idx_d   = bus.id_src_idx;
      src_val_d   = load_val;
      meta_d      = bus.id_meta;
      stall_cnt_d = '0;
    end else begin
      // Patching also runs on bubbles; only the counter is gated by valid.
      if (bus.hold_patch) begin
        src_val_d = hold_val;
      end
      if (valid_q && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      src_idx_q   <= '0;
      src_val_q   <= '0;
      meta_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      src_idx_q   <= src_idx_d;
      src_val_q   <= src_val_d;
      meta_q      <= meta_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.ex_valid     = valid_q;
  assign bus.ex_pc        = pc_q;
  assign bus.ex_src_idx   = src_idx_q;
  assign bus.ex_src_val   = src_val_q;
  assign bus.ex_meta      = meta_q;
  assign bus.ex_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ex_stage_reg.sv
// Bench for ex_stage_reg: two instances (patch-on-load on / off, two WB
// ports) share one stimulus stream and are compared each cycle against a
// behavioural model; directed steps pin literal values.
module tb_ex_stage_reg;
  import ex_pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset, load, flush, hold, id_valid;
  logic [31:0]           id_pc;
  logic [1:0][4:0]       id_idx;
  logic [1:0][31:0]      id_val;
  logic [5:0]            id_meta;
  logic [1:0]            wb_we;
  logic [1:0][4:0]       wb_rd;
  logic [1:0][31:0]      wb_data;

  ex_stage_reg_if #(.NUM_WB(2)) ifa ();
  ex_stage_reg_if #(.NUM_WB(2)) ifb ();

  assign ifa.load = load;        assign ifb.load = load;
  assign ifa.flush = flush;      assign ifb.flush = flush;
  assign ifa.hold_patch = hold;  assign ifb.hold_patch = hold;
  assign ifa.id_valid = id_valid; assign ifb.id_valid = id_valid;
  assign ifa.id_pc = id_pc;      assign ifb.id_pc = id_pc;
  assign ifa.id_src_idx = id_idx; assign ifb.id_src_idx = id_idx;
  assign ifa.id_src_val = id_val; assign ifb.id_src_val = id_val;
  assign ifa.id_meta = id_meta;  assign ifb.id_meta = id_meta;
  assign ifa.wb_we = wb_we;      assign ifb.wb_we = wb_we;
  assign ifa.wb_rd = wb_rd;      assign ifb.wb_rd = wb_rd;
  assign ifa.wb_data = wb_data;  assign ifb.wb_data = wb_data;

  ex_stage_reg #(.NUM_WB(2), .PATCH_ON_LOAD(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  ex_stage_reg #(.NUM_WB(2), .PATCH_ON_LOAD(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic            m_valid [2];
  logic [31:0]     m_pc    [2];
  logic [1:0][4:0] m_idx   [2];
  logic [1:0][31:0] m_val  [2];
  logic [5:0]      m_meta  [2];
  int              m_cnt   [2];

  function automatic logic [31:0] f_patch(input logic [4:0] idx, input logic [31:0] v);
    if (idx == 5'd0) return v;
    for (int j = 0; j < 2; j++)
      if (wb_we[j] && wb_rd[j] == idx) return wb_data[j];
    return v;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_valid[k] <= 1'b0; m_pc[k] <= '0; m_idx[k] <= '0;
        m_val[k] <= '0; m_meta[k] <= '0; m_cnt[k] <= 0;
      end else if (flush) begin
        m_valid[k] <= 1'b0; m_meta[k] <= '0; m_cnt[k] <= 0;
      end else if (load) begin
        m_valid[k] <= id_valid; m_pc[k] <= id_pc; m_idx[k] <= id_idx;
        m_meta[k] <= id_meta; m_cnt[k] <= 0;
        for (int i = 0; i < 2; i++)
          m_val[k][i] <= (k == 0) ? f_patch(id_idx[i], id_val[i]) : id_val[i];
      end else begin
        if (hold)
          for (int i = 0; i < 2; i++) m_val[k][i] <= f_patch(m_idx[k][i], m_val[k][i]);
        if (m_valid[k] && m_cnt[k] < 15) m_cnt[k] <= m_cnt[k] + 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("a.valid", 32'(ifa.ex_valid), 32'(m_valid[0]));
      chk("a.pc",    ifa.ex_pc, m_pc[0]);
      chk("a.idx",   32'(ifa.ex_src_idx), 32'(m_idx[0]));
      chk("a.val0",  ifa.ex_src_val[0], m_val[0][0]);
      chk("a.val1",  ifa.ex_src_val[1], m_val[0][1]);
      chk("a.meta",  32'(ifa.ex_meta), 32'(m_meta[0]));
      chk("a.cnt",   32'(ifa.ex_stall_cnt), 32'(m_cnt[0]));
      chk("b.valid", 32'(ifb.ex_valid), 32'(m_valid[1]));
      chk("b.pc",    ifb.ex_pc, m_pc[1]);
      chk("b.idx",   32'(ifb.ex_src_idx), 32'(m_idx[1]));
      chk("b.val0",  ifb.ex_src_val[0], m_val[1][0]);
      chk("b.val1",  ifb.ex_src_val[1], m_val[1][1]);
      chk("b.meta",  32'(ifb.ex_meta), 32'(m_meta[1]));
      chk("b.cnt",   32'(ifb.ex_stall_cnt), 32'(m_cnt[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; load = 1'b0; flush = 1'b0; hold = 1'b0; id_valid = 1'b0;
    wb_we = 2'b00;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    id_pc = '0; id_idx = '0; id_val = '0; id_meta = '0; wb_rd = '0; wb_data = '0;

    // reset
    reset = 1'b1;
    tick();
    cmp_en = 1'b1;
    chk("rst.valid", 32'(ifa.ex_valid), 32'd0);
    chk("rst.pc",    ifa.ex_pc, 32'd0);
    chk("rst.cnt",   32'(ifa.ex_stall_cnt), 32'd0);

    // load
    idle_inputs();
    load = 1'b1; id_valid = 1'b1; id_pc = 32'h100;
    id_idx[0] = 5'd5; id_idx[1] = 5'd7; id_val[0] = 32'hA; id_val[1] = 32'hB;
    id_meta = 6'h25;
    tick();
    chk("ld.pc",    ifa.ex_pc, 32'h100);
    chk("ld.val0",  ifa.ex_src_val[0], 32'hA);
    chk("ld.val1",  ifa.ex_src_val[1], 32'hB);
    chk("ld.meta",  32'(ifa.ex_meta), 32'h25);
    chk("ld.valid", 32'(ifa.ex_valid), 32'd1);
    chk("ld.cnt",   32'(ifa.ex_stall_cnt), 32'd0);

    // hold patch on src1
    idle_inputs();
    hold = 1'b1; wb_we = 2'b01; wb_rd[0] = 5'd7; wb_data[0] = 32'hDEAD;
    tick();
    chk("hp.val1", ifa.ex_src_val[1], 32'hDEAD);
    chk("hp.val0", ifa.ex_src_val[0], 32'hA);
    chk("hp.cnt",  32'(ifa.ex_stall_cnt), 32'd1);

    // both ports write rd=5: port 0 wins
    wb_we = 2'b11; wb_rd[0] = 5'd5; wb_rd[1] = 5'd5;
    wb_data[0] = 32'h11; wb_data[1] = 32'h22;
    tick();
    chk("prio.val0", ifa.ex_src_val[0], 32'h11);
    chk("prio.cnt",  32'(ifa.ex_stall_cnt), 32'd2);

    // x0 is never patched
    idle_inputs();
    load = 1'b1; id_valid = 1'b1; id_idx[0] = 5'd0; id_val[0] = 32'h33;
    tick();
    idle_inputs();
    hold = 1'b1; wb_we = 2'b11; wb_rd[0] = 5'd0; wb_rd[1] = 5'd0;
    tick();
    chk("x0.val0", ifa.ex_src_val[0], 32'h33);

    // flush beats load
    idle_inputs();
    flush = 1'b1; load = 1'b1; id_valid = 1'b1; id_meta = 6'h3F;
    tick();
    chk("fl.valid", 32'(ifa.ex_valid), 32'd0);
    chk("fl.meta",  32'(ifa.ex_meta), 32'd0);
    chk("fl.cnt",   32'(ifa.ex_stall_cnt), 32'd0);

    // patch on load: instance a patches, instance b does not
    idle_inputs();
    load = 1'b1; id_valid = 1'b1; id_idx[0] = 5'd3; id_val[0] = 32'h1;
    wb_we = 2'b01; wb_rd[0] = 5'd3; wb_data[0] = 32'h9;
    tick();
    chk("pol.a.val0", ifa.ex_src_val[0], 32'h9);
    chk("pol.b.val0", ifb.ex_src_val[0], 32'h1);

    // saturation over 20 idle cycles
    idle_inputs();
    for (int c = 0; c < 15; c++) tick();
    chk("sat.15", 32'(ifa.ex_stall_cnt), 32'd15);
    for (int c = 0; c < 5; c++) tick();
    chk("sat.hold", 32'(ifa.ex_stall_cnt), 32'd15);
    load = 1'b1; id_valid = 1'b1;
    tick();
    chk("sat.load", 32'(ifa.ex_stall_cnt), 32'd0);

    // reset mid-hold, then idle
    idle_inputs();
    hold = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    reset = 1'b1;
    tick();
    chk("mr.valid", 32'(ifa.ex_valid), 32'd0);
    chk("mr.pc",    ifa.ex_pc, 32'd0);
    chk("mr.cnt",   32'(ifa.ex_stall_cnt), 32'd0);
    idle_inputs();
    tick();
    chk("mr.idle.cnt", 32'(ifa.ex_stall_cnt), 32'd0);

    // randomized traffic, checked by the per-cycle compare
    for (int n = 0; n < 2000; n++) begin
      reset    = ($urandom_range(0, 63) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      load     = ($urandom_range(0, 2) == 0);
      hold     = $urandom_range(0, 1) != 0;
      id_valid = ($urandom_range(0, 3) != 0);
      id_pc    = $urandom;
      id_meta  = 6'($urandom);
      for (int i = 0; i < 2; i++) begin
        id_idx[i]  = 5'($urandom_range(0, 7));
        id_val[i]  = $urandom;
        wb_rd[i]   = 5'($urandom_range(0, 7));
        wb_data[i] = $urandom;
      end
      wb_we = 2'($urandom);
      tick();
    end

    idle_inputs();
    tick();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
